mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage; sits between ex_mem and mem_wb. Consumes ex_mem register outputs plus memory-op fields.
//  Non-memory ops pass straight through. Loads/stores run a req/ack transaction on the data-memory port.
//  Stalls the pipeline until the transaction completes, then presents the write-back triple to mem_wb.
// PARAMETERS
//  AW  32  data-memory byte-address width
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low (0 = reset)
//  i_wreg       in   1   register write enable from ex_mem
//  i_wreg_addr  in   5   destination register
//  i_wreg_data  in   32  ALU result (non-memory ops)
//  i_mem_op     in   4   memory op code; see MEM_* in defines.vh
//  i_mem_addr   in   AW  effective byte address
//  i_mem_wdata  in   32  store data, right-aligned
//  dm_req       out  1   memory request, level, held until ack
//  dm_we        out  1   1 = store
//  dm_addr      out  AW  word-aligned address ({i_mem_addr[AW-1:2],2'b00})
//  dm_be        out  4   byte enables, little-endian
//  dm_wdata     out  32  lane-replicated store data
//  dm_rdata     in   32  read data; valid when dm_ack=1
//  dm_ack       in   1   transaction complete, one-cycle pulse
//  o_stall      out  1   1 = upstream stages must hold
//  o_exc_align  out  1   misaligned access, one-cycle pulse
//  o_badvaddr   out  AW  faulting address; valid with o_exc_align
//  o_wreg       out  1   write enable to mem_wb
//  o_wreg_addr  out  5   destination register to mem_wb
//  o_wreg_data  out  32  write-back data to mem_wb
// BEHAVIOUR
//  Reset values
//   - State = IDLE.
//   - Load buffer = 0.
//   - All outputs = 0.
//  FSM states: IDLE, WAIT, DONE.
//  IDLE, non-memory op (MEM_NONE)
//   - o_* = i_* combinationally; o_stall=0; dm_req=0.
//  IDLE, aligned load/store
//   - dm_req=1, o_stall=1, o_wreg=0; next state WAIT.
//  IDLE, misaligned access
//   - Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
//   - No request issued; o_exc_align=1; o_badvaddr=i_mem_addr; o_wreg=0; o_stall=0; stay in IDLE.
//  WAIT
//   - dm_req, dm_we, dm_addr, dm_be, dm_wdata held stable; o_stall=1; o_wreg=0.
//   - On dm_ack: load -> capture the formatted dm_rdata into the load buffer. Next state DONE.
//  DONE (exactly one cycle)
//   - o_stall=0, dm_req=0.
//   - Load: o_wreg=i_wreg, o_wreg_data=buffer. Store: o_wreg=0.
//   - Pipeline advances at the end of this cycle. Next state IDLE.
//  Latency
//   - Memory op: occupies N+2 cycles for ack N>=1 cycles after req; the stage never completes in fewer than 3.
//   - dm_ack is ignored in IDLE and DONE.
//   - Back-to-back memory ops: the next op enters IDLE the cycle after DONE (no bubble is inserted by this block).
//  Store lanes
//   - SB: dm_be=4'b0001<<addr[1:0]; wdata byte replicated x4.
//   - SH: dm_be=4'b0011<<addr[1:0]; wdata half replicated x2.
//   - SW: dm_be=4'hF.
//  Load format
//   - Byte/half selected by addr[1:0], then sign-extended (LB, LH) or zero-extended (LBU, LHU).
//   - dm_be reflects the access size for loads as well.
//  Ordering and reset
//   - Inputs must remain stable while o_stall=1; ex_mem holds them.
//   - Async reset mid-WAIT: return to IDLE and drop dm_req immediately. The memory must tolerate the abandoned request.
//   - Op codes 9..15: treated as MEM_NONE.
// STRUCTURE
//  defines.vh (shared)
//   - `MEM_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
//   - FSM state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
//  Sub-module mem_fmt (combinational): op + addr[1:0] + wdata/rdata -> dm_be, dm_wdata, formatted load data.
//  Top level holds the FSM, load buffer and output muxing.
// TESTING
//  1. MEM_NONE, wreg=1, addr=5'd3, data=32'h1234 -> same cycle o_wreg=1, o_wreg_data=32'h1234, o_stall=0, dm_req=0.
//  2. LB addr=32'h103, rdata=32'h80FF_FF7F, ack 2 cycles after req:
//     -> stall high 3 cycles; DONE o_wreg_data=32'hFFFF_FF80; dm_be=4'b1000.
//     -> repeat with LBU -> 32'h0000_0080.
//  3. SH addr=32'h202, wdata=32'hABCD_5678 -> dm_we=1, dm_be=4'b1100, dm_wdata=32'h5678_5678; DONE o_wreg=0.
//  4. LW addr=32'h101 -> o_exc_align=1 one cycle, o_badvaddr=32'h101, dm_req never rises, o_wreg=0.
//  5. SW then LW back-to-back, ack delay 1 -> two complete transactions; total stall cycles=4; load data correct.
//  6. rst driven low mid-WAIT -> dm_req, o_stall, o_wreg low asynchronously; after release, the next MEM_NONE op passes through cleanly.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the MEM stage.
package mem_stage_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes 9..15 fall outside both ranges and so behave as MEM_NONE.
  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

endpackage

// File: rtl/mem_fmt.sv
// Lane formatting: byte enables, replicated store data, extended load data, alignment check.
module mem_fmt
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [31:0] byte_sh, half_sh;

  assign byte_sh = rdata_i >> {addr_lo_i, 3'b000};
  assign half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};

  always_comb begin
    be_o       = 4'h0;
    wdata_o    = 32'h0;
    ldata_o    = 32'h0;
    misalign_o = 1'b0;
    case (op_i)
      MEM_LB:  begin be_o = 4'b0001 << addr_lo_i; ldata_o = {{24{byte_sh[7]}}, byte_sh[7:0]}; end
      MEM_LBU: begin be_o = 4'b0001 << addr_lo_i; ldata_o = {24'h0, byte_sh[7:0]}; end
      MEM_LH:  begin
        be_o = 4'b0011 << addr_lo_i; misalign_o = addr_lo_i[0];
        ldata_o = {{16{half_sh[15]}}, half_sh[15:0]};
      end
      MEM_LHU: begin
        be_o = 4'b0011 << addr_lo_i; misalign_o = addr_lo_i[0];
        ldata_o = {16'h0, half_sh[15:0]};
      end
      MEM_LW:  begin be_o = 4'hF; misalign_o = |addr_lo_i; ldata_o = rdata_i; end
      MEM_SB:  begin be_o = 4'b0001 << addr_lo_i; wdata_o = {4{wdata_i[7:0]}}; end
      MEM_SH:  begin
        be_o = 4'b0011 << addr_lo_i; misalign_o = addr_lo_i[0];
        wdata_o = {2{wdata_i[15:0]}};
      end
      MEM_SW:  begin be_o = 4'hF; misalign_o = |addr_lo_i; wdata_o = wdata_i; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: pass-through for ALU ops, req/ack data-memory transaction for loads/stores.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wreg,
  input  logic [4:0]    i_wreg_addr,
  input  logic [31:0]   i_wreg_data,
  input  logic [3:0]    i_mem_op,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [31:0]   i_mem_wdata,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  input  logic          dm_ack,
  output logic          o_stall,
  output logic          o_exc_align,
  output logic [AW-1:0] o_badvaddr,
  output logic          o_wreg,
  output logic [4:0]    o_wreg_addr,
  output logic [31:0]   o_wreg_data
);

  state_e      state_q, state_d;
  logic [31:0] lbuf_q, lbuf_d;
  logic        ld, st, mem, mis;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_ldata;

  assign ld  = is_load(i_mem_op);
  assign st  = is_store(i_mem_op);
  assign mem = ld | st;

  mem_fmt u_fmt (
    .op_i       (i_mem_op),
    .addr_lo_i  (i_mem_addr[1:0]),
    .wdata_i    (i_mem_wdata),
    .rdata_i    (dm_rdata),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .ldata_o    (fmt_ldata),
    .misalign_o (mis)
  );

  always_comb begin
    state_d = state_q;
    lbuf_d  = lbuf_q;
    case (state_q)
      ST_IDLE: if (mem && !mis) state_d = ST_WAIT;
      ST_WAIT: if (dm_ack) begin
        state_d = ST_DONE;
        if (ld) lbuf_d = fmt_ldata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lbuf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      lbuf_q  <= lbuf_d;
    end
  end

  // Outputs are forced low while reset is asserted so an abandoned request drops at once.
  always_comb begin
    dm_req      = 1'b0;
    o_stall     = 1'b0;
    o_exc_align = 1'b0;
    o_badvaddr  = '0;
    o_wreg      = 1'b0;
    o_wreg_addr = 5'h0;
    o_wreg_data = 32'h0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (!mem) begin
            o_wreg      = i_wreg;
            o_wreg_addr = i_wreg_addr;
            o_wreg_data = i_wreg_data;
          end else if (mis) begin
            o_exc_align = 1'b1;
            o_badvaddr  = i_mem_addr;
          end else begin
            dm_req  = 1'b1;
            o_stall = 1'b1;
          end
        end
        ST_WAIT: begin
          dm_req  = 1'b1;
          o_stall = 1'b1;
        end
        ST_DONE: begin
          o_wreg      = ld & i_wreg;
          o_wreg_addr = i_wreg_addr;
          o_wreg_data = ld ? lbuf_q : i_wreg_data;
        end
        default: ;
      endcase
    end
  end

  assign dm_we    = dm_req & st;
  assign dm_addr  = dm_req ? {i_mem_addr[AW-1:2], 2'b00} : '0;
  assign dm_be    = dm_req ? fmt_be : 4'h0;
  assign dm_wdata = dm_req ? fmt_wdata : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_wreg = 1'b0;
  logic [4:0]    i_wreg_addr = '0;
  logic [31:0]   i_wreg_data = '0;
  logic [3:0]    i_mem_op = '0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [31:0]   i_mem_wdata = '0;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [3:0]    dm_be;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata = '0;
  logic          dm_ack = 1'b0;
  logic          o_stall, o_exc_align, o_wreg;
  logic [AW-1:0] o_badvaddr;
  logic [4:0]    o_wreg_addr;
  logic [31:0]   o_wreg_data;

  int nvec = 0, nbad = 0;
  int s1, s2;

  mem_stage #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_wreg(i_wreg), .i_wreg_addr(i_wreg_addr), .i_wreg_data(i_wreg_data),
    .i_mem_op(i_mem_op), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .o_stall(o_stall), .o_exc_align(o_exc_align), .o_badvaddr(o_badvaddr),
    .o_wreg(o_wreg), .o_wreg_addr(o_wreg_addr), .o_wreg_data(o_wreg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_none(input logic [4:0] wa, input logic [31:0] wd);
    i_mem_op = 4'd0; i_mem_addr = 32'h0; i_mem_wdata = 32'h0;
    i_wreg = 1'b1; i_wreg_addr = wa; i_wreg_data = wd;
  endtask

  // Called just after a rising edge; ack is pulsed n cycles after req rises.
  task automatic mem_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int n, input logic [31:0] rdata,
                        input logic [3:0] ebe, input logic [31:0] ewdata,
                        input logic [31:0] edata, output int stalls);
    logic is_st;
    logic done;
    is_st = (op >= 4'd6);
    i_mem_op = op; i_mem_addr = addr; i_mem_wdata = wdata;
    i_wreg = 1'b1; i_wreg_addr = 5'd7; i_wreg_data = 32'hDEAD_BEEF;
    dm_rdata = rdata;
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      dm_ack = (k == n);
      @(negedge clk);
      if (k == 0) begin
        chk({tag, ".req"},   {63'h0, dm_req}, 64'h1);
        chk({tag, ".we"},    {63'h0, dm_we}, {63'h0, is_st});
        chk({tag, ".addr"},  {32'h0, dm_addr}, {32'h0, addr[31:2], 2'b00});
        chk({tag, ".be"},    {60'h0, dm_be}, {60'h0, ebe});
        if (is_st) chk({tag, ".wdata"}, {32'h0, dm_wdata}, {32'h0, ewdata});
      end
      if (!o_stall) begin
        chk({tag, ".done_req"}, {63'h0, dm_req}, 64'h0);
        chk({tag, ".done_wreg"}, {63'h0, o_wreg}, {63'h0, !is_st});
        if (!is_st) chk({tag, ".done_data"}, {32'h0, o_wreg_data}, {32'h0, edata});
        chk({tag, ".cycles"}, 64'(k + 1), 64'(n + 2));
        done = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    if (!done) chk({tag, ".timeout"}, 64'h0, 64'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state: outputs low even with a live pass-through op on the inputs
    set_none(5'd3, 32'h1234);
    #12;
    chk("rst.wreg", {63'h0, o_wreg}, 64'h0);
    chk("rst.stall", {63'h0, o_stall}, 64'h0);
    chk("rst.req", {63'h0, dm_req}, 64'h0);
    chk("rst.data", {32'h0, o_wreg_data}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: pass-through
    set_none(5'd3, 32'h1234);
    @(negedge clk);
    chk("none.wreg", {63'h0, o_wreg}, 64'h1);
    chk("none.waddr", {59'h0, o_wreg_addr}, 64'd3);
    chk("none.data", {32'h0, o_wreg_data}, 64'h1234);
    chk("none.stall", {63'h0, o_stall}, 64'h0);
    chk("none.req", {63'h0, dm_req}, 64'h0);
    @(posedge clk); #1;

    // 2: byte/half loads, ack two cycles after req
    mem_op("lb", 4'd1, 32'h103, 32'h0, 2, 32'h80FF_FF7F, 4'b1000, 32'h0, 32'hFFFF_FF80, s1);
    chk("lb.stalls", 64'(s1), 64'd3);
    mem_op("lbu", 4'd2, 32'h103, 32'h0, 2, 32'h80FF_FF7F, 4'b1000, 32'h0, 32'h0000_0080, s1);
    mem_op("lh", 4'd3, 32'h102, 32'h0, 1, 32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001, s1);
    mem_op("lhu", 4'd4, 32'h100, 32'h0, 1, 32'h8001_F00F, 4'b0011, 32'h0, 32'h0000_F00F, s1);

    // 3: stores
    mem_op("sh", 4'd7, 32'h202, 32'hABCD_5678, 1, 32'h0, 4'b1100, 32'h5678_5678, 32'h0, s1);
    mem_op("sb", 4'd6, 32'h001, 32'h1234_56AB, 3, 32'h0, 4'b0010, 32'hABAB_ABAB, 32'h0, s1);
    chk("sb.stalls", 64'(s1), 64'd4);

    // 4: misaligned accesses raise the exception and never request
    i_mem_op = 4'd5; i_mem_addr = 32'h101; i_wreg = 1'b1; i_wreg_addr = 5'd4;
    @(negedge clk);
    chk("mis.exc", {63'h0, o_exc_align}, 64'h1);
    chk("mis.badv", {32'h0, o_badvaddr}, 64'h101);
    chk("mis.req", {63'h0, dm_req}, 64'h0);
    chk("mis.wreg", {63'h0, o_wreg}, 64'h0);
    chk("mis.stall", {63'h0, o_stall}, 64'h0);
    @(posedge clk); #1;
    i_mem_op = 4'd3; i_mem_addr = 32'h203;
    @(negedge clk);
    chk("mish.exc", {63'h0, o_exc_align}, 64'h1);
    chk("mish.req", {63'h0, dm_req}, 64'h0);
    @(posedge clk); #1;
    set_none(5'd5, 32'hCAFE);
    @(negedge clk);
    chk("mis.after_exc", {63'h0, o_exc_align}, 64'h0);
    chk("mis.after_data", {32'h0, o_wreg_data}, 64'hCAFE);
    @(posedge clk); #1;

    // 5: back-to-back SW then LW, ack delay 1
    mem_op("sw", 4'd8, 32'h400, 32'h0BAD_F00D, 1, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0, s1);
    mem_op("lw", 4'd5, 32'h404, 32'h0, 1, 32'h1111_2222, 4'hF, 32'h0, 32'h1111_2222, s2);
    chk("b2b.stalls", 64'(s1 + s2), 64'd4);

    // 6: async reset in the middle of WAIT
    i_mem_op = 4'd5; i_mem_addr = 32'h300; i_wreg = 1'b1; i_wreg_addr = 5'd8;
    @(posedge clk); #2;
    chk("rstw.stall_pre", {63'h0, o_stall}, 64'h1);
    rst = 1'b0;
    #1;
    chk("rstw.req", {63'h0, dm_req}, 64'h0);
    chk("rstw.stall", {63'h0, o_stall}, 64'h0);
    chk("rstw.wreg", {63'h0, o_wreg}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_none(5'd9, 32'h55);
    dm_ack = 1'b1;
    @(negedge clk);
    chk("rstw.pass_wreg", {63'h0, o_wreg}, 64'h1);
    chk("rstw.pass_data", {32'h0, o_wreg_data}, 64'h55);
    chk("rstw.pass_stall", {63'h0, o_stall}, 64'h0);
    chk("rstw.pass_req", {63'h0, dm_req}, 64'h0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    i_wreg_data = 32'h66;
    @(negedge clk);
    chk("rstw.idle_data", {32'h0, o_wreg_data}, 64'h66);
    chk("rstw.idle_stall", {63'h0, o_stall}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
